// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - data-memory address map, STATUS layout and region decode
package mem_map_pkg;

  localparam logic [31:0] TIMER_ADDR  = 32'h0000_0400;
  localparam logic [31:0] TXDATA_ADDR = 32'h0000_0404;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0408;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 3;
  localparam int STAT_CNT_W   = 5;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_TIMER,
    REGION_TXDATA,
    REGION_STATUS,
    REGION_NONE
  } region_e;

  // RAM range is checked first so an oversized RAM shadows the registers.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned ram_words);
    logic [31:0] aligned;
    aligned = addr & 32'hFFFF_FFFC;
    if (aligned < (32'(ram_words) << 2))  return REGION_RAM;
    else if (aligned == TIMER_ADDR)       return REGION_TIMER;
    else if (aligned == TXDATA_ADDR)      return REGION_TXDATA;
    else if (aligned == STATUS_ADDR)      return REGION_STATUS;
    else                                  return REGION_NONE;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with same-edge push/pop when full
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a byte when the head leaves at the same edge.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data memory with byte-lane RAM, free-running timer and TX byte queue
module dmem_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  region_e          region;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      timer;
  logic [31:0]      timer_next;
  logic [31:0]      status_word;
  logic             ovf;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             ovf_clr;

  assign region  = decode_region(ALUResult, RAM_WORDS);
  assign ram_idx = ALUResult[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (MemWrite && region == REGION_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (ByteEn[i]) ram[ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  // Lanes not written still advance, so a partial store never stalls the count.
  always_comb begin
    timer_next = timer + 32'd1;
    if (MemWrite && region == REGION_TIMER) begin
      for (int i = 0; i < 4; i++) begin
        if (ByteEn[i]) timer_next[8*i +: 8] = WriteData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer <= '0;
    else        timer <= timer_next;
  end

  assign fifo_push = MemWrite && region == REGION_TXDATA && ByteEn[0];
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (WriteData[7:0]),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign overflow = fifo_push && fifo_full && !fifo_pop;
  assign ovf_clr  = MemWrite && region == REGION_STATUS && ByteEn[0] && WriteData[STAT_OVF];

  // A fresh overflow wins over a clear landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ovf <= 1'b0;
    else if (overflow) ovf <= 1'b1;
    else if (ovf_clr)  ovf <= 1'b0;
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_OVF]   = ovf;
    status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
  end

  always_comb begin
    ReadData = '0;
    case (region)
      REGION_RAM:    ReadData = ram[ram_idx];
      REGION_TIMER:  ReadData = timer;
      REGION_STATUS: ReadData = status_word;
      default:       ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - vector-table bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] A_TIM = 32'h400;
  localparam logic [31:0] A_TX  = 32'h404;
  localparam logic [31:0] A_ST  = 32'h408;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_tx;
    logic        exp_v;
    logic [7:0]  exp_d;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ByteEn    (ByteEn),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic rdy);
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wdata;
    ByteEn    = be;
    tx_ready  = rdy;
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic rdy,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic chk_tx, input logic exp_v, input logic [7:0] exp_d);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.chk_tx = chk_tx; v.exp_v = exp_v; v.exp_d = exp_d;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Timer value at each check equals the vector index until it is written.
    vecs.push_back(mk(0, A_TIM, 0, 4'h0, 0, 1, 32'd0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 32'h000, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h000, 32'h11223344, 4'h5, 0, 1, 32'hAABBCCDD, 0, 0, 0));
    vecs.push_back(mk(0, 32'h000, 0, 4'h0, 0, 1, 32'hAA22CC44, 0, 0, 0));
    vecs.push_back(mk(1, 32'h004, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h004, 32'hFFFFFFFF, 4'h0, 0, 1, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 32'h006, 0, 4'h0, 0, 1, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(1, 32'h500, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h40C, 0, 4'h0, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, A_TX, 0, 4'h0, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, A_TIM, 0, 4'h0, 0, 1, 32'd10, 0, 0, 0));
    vecs.push_back(mk(1, A_TIM, 32'hFFFFFFFF, 4'hF, 0, 1, 32'd11, 0, 0, 0));
    vecs.push_back(mk(0, A_TIM, 0, 4'h0, 0, 1, 32'hFFFFFFFF, 0, 0, 0));
    vecs.push_back(mk(0, A_TIM, 0, 4'h0, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, A_TIM, 32'h0000AB00, 4'h2, 0, 1, 32'h1, 0, 0, 0));
    vecs.push_back(mk(0, A_TIM, 0, 4'h0, 0, 1, 32'h0000AB02, 0, 0, 0));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 0, 1, 32'h01, 1, 0, 0));
    // Fill with backpressure; lane-0-less push ignored, fifth push overflows.
    vecs.push_back(mk(1, A_TX, 32'h99, 4'hE, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, A_TX, 32'h01, 4'h1, 0, 1, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, A_TX, 32'h02, 4'h1, 0, 0, 0, 1, 1, 8'h01));
    vecs.push_back(mk(1, A_TX, 32'h03, 4'h1, 0, 0, 0, 1, 1, 8'h01));
    vecs.push_back(mk(1, A_TX, 32'h04, 4'h1, 0, 0, 0, 1, 1, 8'h01));
    vecs.push_back(mk(1, A_TX, 32'h05, 4'h1, 0, 0, 0, 1, 1, 8'h01));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 0, 1, 32'h26, 1, 1, 8'h01));
    // Drain with tx_ready 1,0,1,1,1.
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h26, 1, 1, 8'h01));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 0, 1, 32'h1C, 1, 1, 8'h02));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h1C, 1, 1, 8'h02));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h14, 1, 1, 8'h03));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h0C, 1, 1, 8'h04));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 0, 1, 32'h05, 1, 0, 0));
    vecs.push_back(mk(1, A_ST, 32'h04, 4'h1, 1, 1, 32'h05, 1, 0, 0));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 0, 1, 32'h01, 1, 0, 0));
    // Full FIFO with push and pop on the same edge.
    vecs.push_back(mk(1, A_TX, 32'hAA, 4'h1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, A_TX, 32'hBB, 4'h1, 0, 0, 0, 1, 1, 8'hAA));
    vecs.push_back(mk(1, A_TX, 32'hCC, 4'h1, 0, 0, 0, 1, 1, 8'hAA));
    vecs.push_back(mk(1, A_TX, 32'hDD, 4'h1, 0, 0, 0, 1, 1, 8'hAA));
    vecs.push_back(mk(1, A_TX, 32'hEE, 4'h1, 1, 0, 0, 1, 1, 8'hAA));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 0, 1, 32'h22, 1, 1, 8'hBB));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h22, 1, 1, 8'hBB));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h18, 1, 1, 8'hCC));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h10, 1, 1, 8'hDD));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 1, 1, 32'h08, 1, 1, 8'hEE));
    vecs.push_back(mk(0, A_ST, 0, 4'h0, 0, 1, 32'h01, 1, 0, 0));

    reset = 1'b0;
    drive(0, A_ST, 0, 4'h0, 0);
    @(negedge clk);
    #1;
    check("rst_status", ReadData, 32'h01);
    check("rst_valid", {31'b0, tx_valid}, 32'h0);
    ALUResult = A_TIM;
    #1;
    check("rst_timer", ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rdy);
      #1;
      if (vecs[i].chk_rd) check($sformatf("v%0d_rd", i), ReadData, vecs[i].exp_rd);
      if (vecs[i].chk_tx) begin
        check($sformatf("v%0d_valid", i), {31'b0, tx_valid}, {31'b0, vecs[i].exp_v});
        if (vecs[i].exp_v) check($sformatf("v%0d_data", i), {24'b0, tx_data}, {24'b0, vecs[i].exp_d});
      end
      @(negedge clk);
    end

    // Reset pulse between edges with three bytes queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, A_TX, 32'h31 + i, 4'h1, 0);
      @(negedge clk);
    end
    drive(0, A_ST, 0, 4'h0, 0);
    #1;
    check("pre_rst_status", ReadData, 32'h18);
    check("pre_rst_data", {24'b0, tx_data}, 32'h31);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
    check("mid_rst_status", ReadData, 32'h01);
    ALUResult = A_TIM;
    #1;
    check("mid_rst_timer", ReadData, 32'h0);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_timer0", ReadData, 32'h0);
    check("post_rst_valid", {31'b0, tx_valid}, 32'h0);
    @(negedge clk);
    #1;
    check("post_rst_timer1", ReadData, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
